dot_prod_sequencer: RTL and testbench

Host-side controller for the dot-product kernel and its two on-chip operand arrays (a, b).
- Streams N_ELEMS operand pairs into the arrays through the kernel's array-control port.
- Launches the kernel, waits for completion and returns the signed result over a valid/ready handshake.
- Adds abort and a completion timeout.
- Sits between the system bus/DMA front end and the kernel instance.

---
 rtl/dot_prod_pkg.sv | 33 +++
 rtl/dot_prod_timeout.sv | 51 +++++
 rtl/dot_prod_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_dot_prod_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_prod_pkg.sv
// dot_prod_pkg: definitions shared by the dot-product sequencer, the kernel
// wrappers and the benches.
//   - Default values for the job size and the operand/result widths.
//   - The sequencer state encoding seq_state_t.
//   - Small decode helpers that map a state to its output levels.
package dot_prod_pkg;

  localparam int DEF_N_ELEMS        = 1000;
  localparam int DEF_ADDR_W         = 10;
  localparam int DEF_DATA_W         = 27;
  localparam int DEF_RES_W          = 64;
  localparam int DEF_TIMEOUT_CYCLES = 8191;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } seq_state_t;

  // A job is in flight from the first operand load until the result is taken.
  function automatic logic state_is_busy(input seq_state_t s);
    return (s == ST_LOAD) || (s == ST_LAUNCH) || (s == ST_RUN) || (s == ST_DONE);
  endfunction

  // The sequencer owns the array ports except while the kernel is launched or running.
  function automatic logic state_owns_arrays(input seq_state_t s);
    return !((s == ST_LAUNCH) || (s == ST_RUN));
  endfunction

endpackage

// File: rtl/dot_prod_timeout.sv
// dot_prod_timeout: completion watchdog for the kernel run phase.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : zero the counter (takes priority over en)
//   en         : count one cycle; the counter saturates at TIMEOUT_CYCLES
//   expire     : high in the cycle whose edge moves the counter onto
//                TIMEOUT_CYCLES, so the owner can change state on that edge
module dot_prod_timeout
  import dot_prod_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = CNT_ZERO;
    end else if (en && (count_q != CNT_TERM)) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= CNT_ZERO;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = en & ~clr & (count_q == CNT_LAST);

endmodule

// File: rtl/dot_prod_sequencer.sv
// dot_prod_sequencer: host-side controller for the dot-product kernel.
// Streams N_ELEMS operand pairs into the kernel's a/b arrays, launches the
// kernel, waits for its done flag (with a timeout) and hands the signed
// result out over a valid/ready handshake.
//   Host side  : start, abort, init_acc, load_valid/ready/a/b,
//                busy, res_valid/ready/data, timeout_err
//   Kernel side: k_r_enable, k_controlArr, k_init_i, k_init_acc,
//                k_w_enable, k_result, array write ports for a and b
// Array writes are issued in the same cycle as the load handshake, so the
// write enables and write data are the only outputs that follow inputs
// combinationally; all other outputs come straight from flops.
module dot_prod_sequencer
  import dot_prod_pkg::*;
#(
  parameter int N_ELEMS        = DEF_N_ELEMS,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int RES_W          = DEF_RES_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [RES_W-1:0]  init_acc,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_a,
  input  logic [DATA_W-1:0] load_b,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic              timeout_err,
  output logic              k_r_enable,
  output logic              k_controlArr,
  output logic [ADDR_W-1:0] k_init_i,
  output logic [RES_W-1:0]  k_init_acc,
  input  logic              k_w_enable,
  input  logic [RES_W-1:0]  k_result,
  output logic              k_arrWEnable_a,
  output logic              k_arrWEnable_b,
  output logic [ADDR_W-1:0] k_arrAddr_a,
  output logic [ADDR_W-1:0] k_arrAddr_b,
  output logic [DATA_W-1:0] k_arrWData_a,
  output logic [DATA_W-1:0] k_arrWData_b
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_ELEMS - 1);
  localparam logic [RES_W-1:0]  RES_ZERO  = {RES_W{1'b0}};

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RES_W-1:0]  acc_q, acc_d;            // init_acc captured at start
  logic [RES_W-1:0]  res_data_q, res_data_d;
  logic [RES_W-1:0]  k_init_acc_q, k_init_acc_d;
  logic              timeout_err_q, timeout_err_d;
  logic              load_ready_q, load_ready_d;
  logic              busy_q, busy_d;
  logic              res_valid_q, res_valid_d;
  logic              k_r_enable_q, k_r_enable_d;
  logic              k_control_arr_q, k_control_arr_d;

  logic              wr_s;
  logic              tmo_clr_s;
  logic              tmo_en_s;
  logic              tmo_expire_s;

  dot_prod_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmo_clr_s),
    .en     (tmo_en_s),
    .expire (tmo_expire_s)
  );

  // Next state and datapath: abort is tested first in every state that honours it.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    acc_d         = acc_q;
    res_data_d    = res_data_q;
    timeout_err_d = timeout_err_q;
    tmo_clr_s     = 1'b0;
    tmo_en_s      = (state_q == ST_RUN);
    // An abort cycle never writes, even with a handshake on the port.
    wr_s          = (state_q == ST_LOAD) & load_valid & load_ready_q & ~abort;

    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (start) begin
          state_d       = ST_LOAD;
          acc_d         = init_acc;
          addr_d        = ADDR_ZERO;
          timeout_err_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (wr_s) begin
          if (addr_q == ADDR_LAST) begin
            state_d = ST_LAUNCH;
          end else begin
            addr_d = addr_q + ADDR_ONE;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_LAUNCH: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d   = ST_RUN;
          tmo_clr_s = 1'b1;
        end
      end
      ST_RUN: begin
        // Completion is checked before the watchdog so a late done still wins.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (k_w_enable) begin
          state_d    = ST_DONE;
          res_data_d = k_result;
        end else if (tmo_expire_s) begin
          state_d       = ST_ERR;
          timeout_err_d = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output levels are decoded from the next state so they register alongside it.
  always_comb begin
    load_ready_d    = (state_d == ST_LOAD);
    busy_d          = state_is_busy(state_d);
    res_valid_d     = (state_d == ST_DONE);
    k_r_enable_d    = (state_d != ST_RUN);
    k_control_arr_d = state_owns_arrays(state_d);
    if (state_d == ST_LAUNCH) begin
      k_init_acc_d = acc_d;
    end else begin
      k_init_acc_d = k_init_acc_q;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      addr_q          <= ADDR_ZERO;
      acc_q           <= RES_ZERO;
      res_data_q      <= RES_ZERO;
      k_init_acc_q    <= RES_ZERO;
      timeout_err_q   <= 1'b0;
      load_ready_q    <= 1'b0;
      busy_q          <= 1'b0;
      res_valid_q     <= 1'b0;
      k_r_enable_q    <= 1'b1;
      k_control_arr_q <= 1'b1;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      acc_q           <= acc_d;
      res_data_q      <= res_data_d;
      k_init_acc_q    <= k_init_acc_d;
      timeout_err_q   <= timeout_err_d;
      load_ready_q    <= load_ready_d;
      busy_q          <= busy_d;
      res_valid_q     <= res_valid_d;
      k_r_enable_q    <= k_r_enable_d;
      k_control_arr_q <= k_control_arr_d;
    end
  end

  assign load_ready     = load_ready_q;
  assign busy           = busy_q;
  assign res_valid      = res_valid_q;
  assign res_data       = res_data_q;
  assign timeout_err    = timeout_err_q;
  assign k_r_enable     = k_r_enable_q;
  assign k_controlArr   = k_control_arr_q;
  assign k_init_i       = ADDR_ZERO;
  assign k_init_acc     = k_init_acc_q;
  assign k_arrWEnable_a = wr_s;
  assign k_arrWEnable_b = wr_s;
  assign k_arrAddr_a    = addr_q;
  assign k_arrAddr_b    = addr_q;
  assign k_arrWData_a   = load_a;
  assign k_arrWData_b   = load_b;

endmodule

// File: tb/tb_dot_prod_sequencer.sv
// tb_dot_prod_sequencer: self-checking bench for dot_prod_sequencer.
// A behavioural kernel holds the a/b arrays written through the array port
// and, once released from r_enable, returns init_acc + sum(a*b) after a
// random latency (or never, in hang mode). Expected results come from the
// operand vectors the bench itself sent.
module tb_dot_prod_sequencer;
  import dot_prod_pkg::*;

  localparam int NE  = 1000;
  localparam int AW  = 10;
  localparam int DW  = 27;
  localparam int RW  = 64;
  localparam int TMO = 8191;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start = 1'b0, abort = 1'b0, load_valid = 1'b0, res_ready = 1'b0;
  logic [RW-1:0] init_acc = '0;
  logic [DW-1:0] load_a = '0, load_b = '0;
  logic          load_ready, busy, res_valid, timeout_err;
  logic [RW-1:0] res_data, k_init_acc;
  logic          k_r_enable, k_controlArr, k_we_a, k_we_b;
  logic [AW-1:0] k_init_i, k_addr_a, k_addr_b;
  logic [DW-1:0] k_wdata_a, k_wdata_b;

  int checks = 0;
  int errors = 0;

  // Behavioural kernel and write monitor state
  bit                   kern_hang = 1'b0;
  int                   kern_lat  = 3;
  logic signed [DW-1:0] kmem_a [1024];
  logic signed [DW-1:0] kmem_b [1024];
  logic                 kw   = 1'b0;
  logic [RW-1:0]        kres = '0;
  logic [RW-1:0]        kacc = '0;
  int                   kcnt = 0;
  int                   wr_cnt = 0, wr_pair_err = 0, launch_cnt = 0;
  logic [AW-1:0]        wr_log [16384];

  logic signed [DW-1:0] stim_a [NE];
  logic signed [DW-1:0] stim_b [NE];

  dot_prod_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .init_acc(init_acc),
    .load_valid(load_valid), .load_ready(load_ready), .load_a(load_a), .load_b(load_b),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .timeout_err(timeout_err), .k_r_enable(k_r_enable), .k_controlArr(k_controlArr),
    .k_init_i(k_init_i), .k_init_acc(k_init_acc), .k_w_enable(kw), .k_result(kres),
    .k_arrWEnable_a(k_we_a), .k_arrWEnable_b(k_we_b),
    .k_arrAddr_a(k_addr_a), .k_arrAddr_b(k_addr_b),
    .k_arrWData_a(k_wdata_a), .k_arrWData_b(k_wdata_b)
  );

  always #5 clk = ~clk;

  function automatic longint kdot();
    longint s = 0;
    for (int i = 0; i < NE; i++) s += longint'(kmem_a[i]) * longint'(kmem_b[i]);
    return s;
  endfunction

  function automatic logic [RW-1:0] ref_result(input logic [RW-1:0] init);
    longint s = longint'(init);
    for (int i = 0; i < NE; i++) s += longint'(stim_a[i]) * longint'(stim_b[i]);
    return RW'(s);
  endfunction

  // Kernel model plus monitor of array writes and launches
  always @(posedge clk) begin
    if (k_we_a) kmem_a[k_addr_a] <= k_wdata_a;
    if (k_we_b) kmem_b[k_addr_b] <= k_wdata_b;
    if (k_we_a || k_we_b) begin
      wr_log[wr_cnt % 16384] <= k_addr_a;
      wr_cnt <= wr_cnt + 1;
      if (!(k_we_a && k_we_b) || (k_addr_a != k_addr_b)) wr_pair_err <= wr_pair_err + 1;
    end
    if (k_r_enable && !k_controlArr) launch_cnt <= launch_cnt + 1;
    if (k_r_enable) begin
      kw <= 1'b0; kcnt <= 0; kacc <= k_init_acc;
    end else if (!kern_hang && !kw) begin
      if (kcnt == kern_lat) begin
        kw   <= 1'b1;
        kres <= kacc + RW'(kdot());
      end
      kcnt <= kcnt + 1;
    end
  end

  task automatic do_start(input logic [RW-1:0] acc);
    @(negedge clk); start = 1'b1; init_acc = acc;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic drive_load(input bit bp, input int abort_at, output bit timed_out);
    int i = 0; int cyc = 0; bit vld; bit hs;
    timed_out = 1'b0;
    while (i < NE) begin
      @(negedge clk);
      if (cyc > 20000) begin timed_out = 1'b1; break; end
      vld = bp ? cyc[0] : 1'b1;
      load_valid = vld; load_a = stim_a[i]; load_b = stim_b[i];
      hs = vld && load_ready;
      if (hs && (i == abort_at)) begin abort = 1'b1; i = NE; end
      else if (hs) i++;
      cyc++;
    end
    @(negedge clk); load_valid = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_run(output bit ok);
    int n = 0;
    while (k_r_enable !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    ok = (k_r_enable === 1'b0);
  endtask

  task automatic wait_result(output bit ok);
    int n = 0;
    while (res_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    ok = (res_valid === 1'b1);
  endtask

  task automatic ack_result();
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NE; i++) begin stim_a[i] = DW'($urandom); stim_b[i] = DW'($urandom); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({load_ready, busy, res_valid, timeout_err, k_r_enable, k_controlArr, k_we_a, k_we_b} !== 8'b0000_1100) begin
      errors++; $display("FAIL reset_ctrl got %b want 00001100",
        {load_ready, busy, res_valid, timeout_err, k_r_enable, k_controlArr, k_we_a, k_we_b});
    end
    checks++;
    if (res_data !== 64'd0 || k_init_acc !== 64'd0 || k_init_i !== 10'd0) begin
      errors++; $display("FAIL reset_data got res=%0h acc=%0h i=%0h want 0", res_data, k_init_acc, k_init_i);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || load_ready !== 1'b0 || k_r_enable !== 1'b1) begin
      errors++; $display("FAIL idle_after_reset got busy=%b rdy=%b ren=%b want 0 0 1", busy, load_ready, k_r_enable);
    end
  endtask

  task automatic test_basic();
    bit to, ok;
    for (int i = 0; i < NE; i++) begin stim_a[i] = DW'(i + 1); stim_b[i] = DW'(2); end
    kern_hang = 1'b0; kern_lat = $urandom_range(1, 20);
    do_start(64'd0);
    drive_load(1'b0, -1, to);
    checks++; if (to) begin errors++; $display("FAIL basic_load timed out got %0d writes want %0d", wr_cnt, NE); end
    wait_result(ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_valid got res_valid=%b want 1", res_valid); end
    checks++;
    if (res_data !== 64'd1001000) begin errors++; $display("FAIL basic_result got %0d want 1001000", res_data); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); start = (c == 3);
      checks++;
      if (res_valid !== 1'b1 || res_data !== 64'd1001000) begin
        errors++; $display("FAIL basic_hold cycle %0d got valid=%b data=%0d want 1 1001000", c, res_valid, res_data);
      end
    end
    // start coinciding with the result handshake must be ignored
    res_ready = 1'b1; start = 1'b1;
    @(negedge clk); res_ready = 1'b0; start = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b0) begin
      errors++; $display("FAIL basic_release got valid=%b busy=%b rdy=%b want 0 0 0", res_valid, busy, load_ready);
    end
  endtask

  task automatic test_signed();
    bit to, ok;
    for (int i = 0; i < NE; i++) begin stim_a[i] = -DW'(1); stim_b[i] = DW'(1); end
    kern_lat = $urandom_range(1, 20);
    do_start(64'hFFFF_FFFF_FFFF_FFFB);
    drive_load(1'b0, -1, to);
    wait_result(ok);
    checks++;
    if (!ok || to || res_data !== 64'hFFFF_FFFF_FFFF_FC13) begin
      errors++; $display("FAIL signed_result got %0h want FFFFFFFFFFFFFC13", res_data);
    end
    ack_result();
  endtask

  task automatic test_backpressure();
    bit to, ok; int base, lbase, order_err;
    logic [RW-1:0] acc, exp_res;
    fill_random(); acc = {$urandom, $urandom}; exp_res = ref_result(acc);
    kern_lat = $urandom_range(1, 20);
    base = wr_cnt; lbase = launch_cnt; order_err = 0;
    do_start(acc);
    drive_load(1'b1, -1, to);
    wait_result(ok);
    checks++;
    if (wr_cnt - base !== NE) begin errors++; $display("FAIL bp_write_count got %0d want %0d", wr_cnt - base, NE); end
    for (int k = 0; k < NE; k++) if (wr_log[(base + k) % 16384] != AW'(k)) order_err++;
    checks++;
    if (order_err !== 0) begin errors++; $display("FAIL bp_addr_order got %0d misordered want 0", order_err); end
    checks++;
    if (wr_pair_err !== 0) begin errors++; $display("FAIL bp_ab_pair got %0d bad writes want 0", wr_pair_err); end
    checks++;
    if (launch_cnt - lbase !== 1) begin errors++; $display("FAIL bp_launch got %0d launches want 1", launch_cnt - lbase); end
    checks++;
    if (!ok || to || res_data !== exp_res) begin errors++; $display("FAIL bp_result got %0h want %0h", res_data, exp_res); end
    ack_result();
  endtask

  task automatic test_back_to_back();
    bit to, ok;
    logic [RW-1:0] acc, exp_res;
    for (int j = 0; j < 2; j++) begin
      fill_random(); acc = {$urandom, $urandom}; exp_res = ref_result(acc);
      kern_lat = $urandom_range(1, 20);
      do_start(acc);
      drive_load(1'b0, -1, to);
      wait_result(ok);
      checks++;
      if (!ok || to || res_data !== exp_res) begin
        errors++; $display("FAIL b2b_result job %0d got %0h want %0h", j, res_data, exp_res);
      end
      ack_result();
    end
  endtask

  task automatic test_timeout();
    bit to, ok; int cyc, base;
    logic [RW-1:0] acc, exp_res;
    fill_random(); acc = {$urandom, $urandom};
    kern_hang = 1'b1;
    do_start(acc);
    drive_load(1'b0, -1, to);
    wait_run(ok);
    checks++; if (!ok) begin errors++; $display("FAIL tmo_run_entry got k_r_enable=%b want 0", k_r_enable); end
    cyc = 0;
    while (timeout_err !== 1'b1 && cyc < TMO + 50) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc !== TMO) begin errors++; $display("FAIL tmo_latency got %0d cycles want %0d", cyc, TMO); end
    checks++;
    if (k_r_enable !== 1'b1 || k_controlArr !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL tmo_err_outputs got ren=%b ctl=%b busy=%b vld=%b want 1 1 0 0",
        k_r_enable, k_controlArr, busy, res_valid);
    end
    // abort is ignored in ERR and the flag stays sticky
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %b want 1", timeout_err); end
    kern_hang = 1'b0; kern_lat = $urandom_range(1, 20);
    fill_random(); exp_res = ref_result(acc); base = wr_cnt;
    do_start(acc);
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b1 || load_ready !== 1'b1) begin
      errors++; $display("FAIL tmo_restart got err=%b busy=%b rdy=%b want 0 1 1", timeout_err, busy, load_ready);
    end
    drive_load(1'b0, -1, to);
    checks++;
    if (wr_log[base % 16384] !== 10'd0 || wr_cnt - base !== NE) begin
      errors++; $display("FAIL tmo_restart_addr got first=%0d n=%0d want 0 %0d", wr_log[base % 16384], wr_cnt - base, NE);
    end
    wait_result(ok);
    checks++;
    if (!ok || res_data !== exp_res) begin errors++; $display("FAIL tmo_restart_result got %0h want %0h", res_data, exp_res); end
    ack_result();
  endtask

  task automatic test_abort();
    bit to, ok; int base;
    logic [RW-1:0] acc, exp_res;
    fill_random(); acc = {$urandom, $urandom};
    base = wr_cnt;
    do_start(acc);
    drive_load(1'b0, 500, to);
    checks++;
    if (busy !== 1'b0 || load_ready !== 1'b0 || k_controlArr !== 1'b1) begin
      errors++; $display("FAIL abort_load_idle got busy=%b rdy=%b ctl=%b want 0 0 1", busy, load_ready, k_controlArr);
    end
    checks++;
    if (wr_cnt - base !== 500 || wr_log[(base + 499) % 16384] !== 10'd499) begin
      errors++; $display("FAIL abort_no_write got n=%0d last=%0d want 500 499", wr_cnt - base, wr_log[(base + 499) % 16384]);
    end
    fill_random(); exp_res = ref_result(acc); base = wr_cnt;
    kern_lat = $urandom_range(1, 20);
    do_start(acc);
    drive_load(1'b0, -1, to);
    wait_result(ok);
    checks++;
    if (wr_log[base % 16384] !== 10'd0 || !ok || res_data !== exp_res) begin
      errors++; $display("FAIL abort_rerun got first=%0d res=%0h want 0 %0h", wr_log[base % 16384], res_data, exp_res);
    end
    ack_result();
    // abort while the kernel is running
    kern_hang = 1'b1;
    do_start(acc);
    drive_load(1'b0, -1, to);
    wait_run(ok);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    checks++;
    if (!ok || busy !== 1'b0 || k_r_enable !== 1'b1 || k_controlArr !== 1'b1 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL abort_run got busy=%b ren=%b ctl=%b err=%b want 0 1 1 0",
        busy, k_r_enable, k_controlArr, timeout_err);
    end
    kern_hang = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    bit to, ok;
    fill_random();
    kern_hang = 1'b1;
    do_start({$urandom, $urandom});
    drive_load(1'b0, -1, to);
    wait_run(ok);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    checks++;
    if (!ok || {load_ready, busy, res_valid, timeout_err, k_r_enable, k_controlArr} !== 6'b000011) begin
      errors++; $display("FAIL reset_mid_run got %b want 000011",
        {load_ready, busy, res_valid, timeout_err, k_r_enable, k_controlArr});
    end
    checks++;
    if (res_data !== 64'd0 || k_init_acc !== 64'd0) begin
      errors++; $display("FAIL reset_mid_run_data got res=%0h acc=%0h want 0 0", res_data, k_init_acc);
    end
    @(negedge clk); rst_n = 1'b1; kern_hang = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    test_abort();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
